uart_rx_deserializer: RTL



---
 rtl/uart_rx_deserializer.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive path from the rx_i pad to the RX FIFO push port.
//   Double-flop synchronizes rx_i, runs a 16x-oversampled frame FSM
//   (IDLE/START/DATA/PARITY/STOP), then emits one push strobe per frame, or an
//   overrun pulse when the FIFO cannot accept the character.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   baud_tick_i        one-clk pulse at 16x baud; every state advance waits for it
//   rx_i               asynchronous serial input, idle high
//   wlen_i, parity_*   LCR line format, latched when a start bit is taken
//   rx_ready_i         RX FIFO not full
//   rx_data_o          received character, right-justified, zero-extended
//   rx_valid_o         one-clk push strobe
//   parity_err_o, framing_err_o, break_o   character status, held until next push
//   overrun_o          one-clk pulse, character dropped
//   busy_o             receiver is inside a frame
// Optional: define UART_RX_BREAK_EN to flag break frames on break_o and hold the
//   receiver unarmed until the line returns high; otherwise break_o is tied 0.
module uart_rx_deserializer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_tick_i,
    input  logic       rx_i,
    input  logic [1:0] wlen_i,
    input  logic       parity_en_i,
    input  logic       parity_even_i,
    input  logic       parity_stick_i,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       framing_err_o,
    output logic       overrun_o,
    output logic       break_o,
    output logic       busy_o
);

    localparam int unsigned TCNT_W   = 4;
    localparam int unsigned BIDX_W   = 3;
    localparam int unsigned DATA_W   = 8;
    localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    state_e              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                armed_q, armed_d;
    logic [BIDX_W-1:0]   bit_q, bit_d;
    logic [1:0]          wlen_q, wlen_d;
    logic                pen_q, pen_d;
    logic                peven_q, peven_d;
    logic                pstick_q, pstick_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                emit_q, emit_d;

    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                parity_err_q, parity_err_d;
    logic                framing_err_q, framing_err_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;

    logic                exp_par;
    logic                last_bit;
    logic                brk_frame;

`ifdef UART_RX_BREAK_EN
    logic pbit_q, pbit_d;
    logic brk_q, brk_d;
    logic break_q, break_d;
`endif

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign exp_par  = pstick_q ? ~peven_q : (peven_q ? ^shift_q : ~(^shift_q));
    assign last_bit = (bit_q == (BIDX_W'(wlen_q) + BIDX_W'(4)));

    // Break frame: all data bits 0, parity bit 0 when enabled, first stop bit 0.
`ifdef UART_RX_BREAK_EN
    assign brk_frame = (shift_q == '0) && !rx_s && (!pen_q || !pbit_q);
`else
    assign brk_frame = 1'b0;
`endif

    // Next-state and output logic.
    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], rx_i};
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        armed_d       = armed_q;
        bit_d         = bit_q;
        wlen_d        = wlen_q;
        pen_d         = pen_q;
        peven_d       = peven_q;
        pstick_d      = pstick_q;
        shift_d       = shift_q;
        perr_d        = perr_q;
        ferr_d        = ferr_q;
        emit_d        = 1'b0;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overrun_d     = 1'b0;
`ifdef UART_RX_BREAK_EN
        pbit_d        = pbit_q;
        brk_d         = brk_q;
        break_d       = break_q;
`endif

        // Output cycle, one clk after the stop sample; runs alongside the FSM.
        if (emit_q) begin
            if (rx_ready_i) begin
                rx_valid_d    = 1'b1;
                rx_data_d     = shift_q;
                framing_err_d = ferr_q;
`ifdef UART_RX_BREAK_EN
                parity_err_d  = perr_q & ~brk_q;
                break_d       = brk_q;
`else
                parity_err_d  = perr_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (baud_tick_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d  = S_START;
                        tcnt_d   = '0;
                        bit_d    = '0;
                        shift_d  = '0;
                        perr_d   = 1'b0;
                        ferr_d   = 1'b0;
                        wlen_d   = wlen_i;
                        pen_d    = parity_en_i;
                        peven_d  = parity_even_i;
                        pstick_d = parity_stick_i;
`ifdef UART_RX_BREAK_EN
                        pbit_d   = 1'b0;
                        brk_d    = 1'b0;
`endif
                    end
                end
                S_START: begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (tcnt_q == TCNT_MID) begin
                        if (!rx_s) begin
                            state_d = S_DATA;
                            tcnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (tcnt_q == TCNT_LAST) begin
                        shift_d[bit_q] = rx_s;
                        bit_d          = bit_q + BIDX_W'(1);
                        if (last_bit) begin
                            state_d = pen_q ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (tcnt_q == TCNT_LAST) begin
                        perr_d  = (rx_s != exp_par);
`ifdef UART_RX_BREAK_EN
                        pbit_d  = rx_s;
`endif
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (tcnt_q == TCNT_LAST) begin
                        ferr_d  = ~rx_s;
                        emit_d  = 1'b1;
                        state_d = S_IDLE;
                        // A low stop bit leaves us unarmed until the line is seen high.
                        armed_d = rx_s & ~brk_frame;
`ifdef UART_RX_BREAK_EN
                        brk_d   = brk_frame;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q        <= '1;
            state_q       <= S_IDLE;
            tcnt_q        <= '0;
            armed_q       <= 1'b0;
            bit_q         <= '0;
            wlen_q        <= '0;
            pen_q         <= 1'b0;
            peven_q       <= 1'b0;
            pstick_q      <= 1'b0;
            shift_q       <= '0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            emit_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_BREAK_EN
            pbit_q        <= 1'b0;
            brk_q         <= 1'b0;
            break_q       <= 1'b0;
`endif
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            armed_q       <= armed_d;
            bit_q         <= bit_d;
            wlen_q        <= wlen_d;
            pen_q         <= pen_d;
            peven_q       <= peven_d;
            pstick_q      <= pstick_d;
            shift_q       <= shift_d;
            perr_q        <= perr_d;
            ferr_q        <= ferr_d;
            emit_q        <= emit_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
`ifdef UART_RX_BREAK_EN
            pbit_q        <= pbit_d;
            brk_q         <= brk_d;
            break_q       <= break_d;
`endif
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign parity_err_o  = parity_err_q;
    assign framing_err_o = framing_err_q;
    assign overrun_o     = overrun_q;
    assign busy_o        = busy_q;
`ifdef UART_RX_BREAK_EN
    assign break_o       = break_q;
`else
    assign break_o       = 1'b0;
`endif

endmodule
